// File: rtl/wb_thread_regfile.sv
// Multithreaded register file fed by write-back: one bank per thread, two synchronous read ports.
// Optional macro WB_BYPASS_EN makes a same-cycle write to the read address visible write-first.
module wb_thread_regfile #(
  parameter int DATA_WIDTH        = 64,
  parameter int REG_INDEX_BITS    = 5,
  parameter int THREAD_INDEX_BITS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_write_back_flag,
  input  logic [REG_INDEX_BITS-1:0]    in_reg_index,
  input  logic [THREAD_INDEX_BITS-1:0] in_thread_index,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [THREAD_INDEX_BITS-1:0] rd_thread_index,
  input  logic [REG_INDEX_BITS-1:0]    rd_a_index,
  input  logic [REG_INDEX_BITS-1:0]    rd_b_index,
  output logic [DATA_WIDTH-1:0]        rd_a_data,
  output logic [DATA_WIDTH-1:0]        rd_b_data,
  output logic                         ready,
  output logic                         dropped_write
);

  localparam int ADDR_BITS = REG_INDEX_BITS + THREAD_INDEX_BITS;
  localparam int ENTRIES   = 32'd1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0]      ADDR_ZERO = {ADDR_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0]      ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0]      LAST_ADDR = {ADDR_BITS{1'b1}};
  localparam logic [REG_INDEX_BITS-1:0] REG_ZERO  = {REG_INDEX_BITS{1'b0}};
  localparam logic [DATA_WIDTH-1:0]     DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                  state_r;
  logic [ADDR_BITS-1:0]    scrub_ctr_r;
  logic                    ready_r;
  logic                    dropped_r;
  logic [DATA_WIDTH-1:0]   rd_a_r;
  logic [DATA_WIDTH-1:0]   rd_b_r;

  // No reset on the array itself; the scrub FSM clears it so it can map to block RAM.
  logic [DATA_WIDTH-1:0]   mem_r [ENTRIES];

  logic                    mem_we_s;
  logic [ADDR_BITS-1:0]    mem_waddr_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_s;
  logic [ADDR_BITS-1:0]    rd_a_addr_s;
  logic [ADDR_BITS-1:0]    rd_b_addr_s;
  logic                    byp_a_s;
  logic                    byp_b_s;

  assign rd_a_addr_s = {rd_thread_index, rd_a_index};
  assign rd_b_addr_s = {rd_thread_index, rd_b_index};

  // Select the single storage write: scrub zeroes, or a write-back to a nonzero register.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = ADDR_ZERO;
    mem_wdata_s = DATA_ZERO;
    if (reset) begin
      mem_we_s = 1'b0;
    end else if (state_r == SCRUB) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = scrub_ctr_r;
      mem_wdata_s = DATA_ZERO;
    end else if (in_write_back_flag && (in_reg_index != REG_ZERO)) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = {in_thread_index, in_reg_index};
      mem_wdata_s = in_data;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Same-cycle write hazard detection for each read port.
  always_comb begin
    byp_a_s = 1'b0;
    byp_b_s = 1'b0;
`ifdef WB_BYPASS_EN
    if (in_write_back_flag && (in_reg_index != REG_ZERO) &&
        (in_thread_index == rd_thread_index)) begin
      byp_a_s = (in_reg_index == rd_a_index);
      byp_b_s = (in_reg_index == rd_b_index);
    end else begin
      byp_a_s = 1'b0;
      byp_b_s = 1'b0;
    end
`endif
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Scrub/run control with registered ready and dropped-write pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= SCRUB;
      scrub_ctr_r <= ADDR_ZERO;
      ready_r     <= 1'b0;
      dropped_r   <= 1'b0;
    end else begin
      case (state_r)
        SCRUB: begin
          scrub_ctr_r <= scrub_ctr_r + ADDR_ONE;
          dropped_r   <= in_write_back_flag;
          if (scrub_ctr_r == LAST_ADDR) begin
            state_r <= RUN;
            ready_r <= 1'b1;
          end else begin
            state_r <= SCRUB;
            ready_r <= 1'b0;
          end
        end
        RUN: begin
          state_r     <= RUN;
          scrub_ctr_r <= scrub_ctr_r;
          ready_r     <= 1'b1;
          dropped_r   <= 1'b0;
        end
        default: begin
          state_r     <= SCRUB;
          scrub_ctr_r <= ADDR_ZERO;
          ready_r     <= 1'b0;
          dropped_r   <= 1'b0;
        end
      endcase
    end
  end

  // Registered read ports; register 0 and the scrub phase always return zero.
  always_ff @(posedge clk) begin
    if (reset || (state_r != RUN)) begin
      rd_a_r <= DATA_ZERO;
      rd_b_r <= DATA_ZERO;
    end else begin
      if (byp_a_s) begin
        rd_a_r <= in_data;
      end else if (rd_a_index == REG_ZERO) begin
        rd_a_r <= DATA_ZERO;
      end else begin
        rd_a_r <= mem_r[rd_a_addr_s];
      end
      if (byp_b_s) begin
        rd_b_r <= in_data;
      end else if (rd_b_index == REG_ZERO) begin
        rd_b_r <= DATA_ZERO;
      end else begin
        rd_b_r <= mem_r[rd_b_addr_s];
      end
    end
  end

  assign rd_a_data     = rd_a_r;
  assign rd_b_data     = rd_b_r;
  assign ready         = ready_r;
  assign dropped_write = dropped_r;

endmodule

// File: tb/tb_wb_thread_regfile.sv
// Directed self-checking bench for wb_thread_regfile (honours WB_BYPASS_EN when defined).
module tb_wb_thread_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_write_back_flag;
  logic [4:0]  in_reg_index;
  logic [2:0]  in_thread_index;
  logic [63:0] in_data;
  logic [2:0]  rd_thread_index;
  logic [4:0]  rd_a_index;
  logic [4:0]  rd_b_index;
  logic [63:0] rd_a_data;
  logic [63:0] rd_b_data;
  logic        ready;
  logic        dropped_write;

  int err_cnt = 0;
  int chk_cnt = 0;

  wb_thread_regfile dut (
    .clk                (clk),
    .reset              (reset),
    .in_write_back_flag (in_write_back_flag),
    .in_reg_index       (in_reg_index),
    .in_thread_index    (in_thread_index),
    .in_data            (in_data),
    .rd_thread_index    (rd_thread_index),
    .rd_a_index         (rd_a_index),
    .rd_b_index         (rd_b_index),
    .rd_a_data          (rd_a_data),
    .rd_b_data          (rd_b_data),
    .ready              (ready),
    .dropped_write      (dropped_write)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] t, input logic [4:0] r, input logic [63:0] d);
    in_write_back_flag = 1'b1;
    in_thread_index    = t;
    in_reg_index       = r;
    in_data            = d;
  endtask

  task automatic rd(input logic [2:0] t, input logic [4:0] a, input logic [4:0] b);
    rd_thread_index = t;
    rd_a_index      = a;
    rd_b_index      = b;
  endtask

  // Entered in scrub cycle 0; leaves in cycle 256. Optionally injects a write at cycle 10.
  task automatic scrub_phase(input string tag, input bit inject);
    int low_bad  = 0;
    int drop_bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (ready !== 1'b0 || rd_a_data !== 64'd0 || rd_b_data !== 64'd0) low_bad++;
      if (inject && (dropped_write !== (i == 11))) drop_bad++;
      if (inject && i == 11) check_eq({tag, "_drop_pulse"}, {63'd0, dropped_write}, 64'd1);
      if (inject && i == 10) wr(3'd0, 5'd3, 64'h55);
      else in_write_back_flag = 1'b0;
      tick();
    end
    check_eq({tag, "_low_cycles"}, 64'(low_bad), 64'd0);
    check_eq({tag, "_drop_pattern"}, 64'(drop_bad), 64'd0);
    check_eq({tag, "_ready_256"}, {63'd0, ready}, 64'd1);
    check_eq({tag, "_drop_after"}, {63'd0, dropped_write}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    in_write_back_flag = 1'b0;
    in_reg_index = 5'd0;
    in_thread_index = 3'd0;
    in_data = 64'd0;
    rd(3'd1, 5'd1, 5'd2);
    tick(); tick(); tick();
    check_eq("rst_ready", {63'd0, ready}, 64'd0);
    check_eq("rst_drop", {63'd0, dropped_write}, 64'd0);
    check_eq("rst_rd_a", rd_a_data, 64'd0);
    check_eq("rst_rd_b", rd_b_data, 64'd0);

    // First scrub, with a write injected at scrub cycle 10.
    reset = 1'b0;
    scrub_phase("scrub1", 1'b1);

    // Every register of threads 0 and 7 reads zero.
    for (int t = 0; t < 8; t += 7) begin
      for (int r = 0; r < 32; r++) begin
        rd(3'(t), 5'(r), 5'(31 - r));
        tick();
        check_eq("scrub_zero_a", rd_a_data, 64'd0);
        check_eq("scrub_zero_b", rd_b_data, 64'd0);
      end
    end
    rd(3'd0, 5'd3, 5'd3);
    tick();
    check_eq("drop_t0r3", rd_a_data, 64'd0);

    // Write then read; other thread untouched.
    wr(3'd2, 5'd5, 64'hDEADBEEF_00000001);
    tick();
    in_write_back_flag = 1'b0;
    rd(3'd2, 5'd5, 5'd6);
    tick();
    check_eq("wr_t2r5", rd_a_data, 64'hDEADBEEF_00000001);
    check_eq("wr_t2r6", rd_b_data, 64'd0);
    rd(3'd3, 5'd4, 5'd5);
    tick();
    check_eq("wr_t3r5", rd_b_data, 64'd0);

    // Register 0 writes are discarded silently.
    wr(3'd1, 5'd0, 64'hFFFFFFFF_FFFFFFFF);
    tick();
    in_write_back_flag = 1'b0;
    check_eq("r0_no_drop", {63'd0, dropped_write}, 64'd0);
    rd(3'd1, 5'd0, 5'd0);
    tick();
    check_eq("r0_read_a", rd_a_data, 64'd0);
    check_eq("r0_read_b", rd_b_data, 64'd0);

    // Same-cycle write/read collision on both ports.
    wr(3'd4, 5'd9, 64'h1234);
    rd(3'd4, 5'd9, 5'd9);
    tick();
    in_write_back_flag = 1'b0;
`ifdef WB_BYPASS_EN
    check_eq("coll_a", rd_a_data, 64'h1234);
    check_eq("coll_b", rd_b_data, 64'h1234);
`else
    check_eq("coll_a", rd_a_data, 64'd0);
    check_eq("coll_b", rd_b_data, 64'd0);
`endif
    tick();
    check_eq("coll_after_a", rd_a_data, 64'h1234);
    check_eq("coll_after_b", rd_b_data, 64'h1234);

    // Bank independence with the same register index in another thread.
    wr(3'd6, 5'd9, 64'h777);
    rd(3'd0, 5'd1, 5'd2);
    tick();
    in_write_back_flag = 1'b0;
    rd(3'd4, 5'd9, 5'd5);
    tick();
    check_eq("bank_t4r9", rd_a_data, 64'h1234);
    check_eq("bank_t4r5", rd_b_data, 64'd0);
    rd(3'd6, 5'd8, 5'd9);
    tick();
    check_eq("bank_t6r8", rd_a_data, 64'd0);
    check_eq("bank_t6r9", rd_b_data, 64'h777);

    // Reset mid-operation: write, reset, interrupt the second scrub at cycle 100.
    wr(3'd5, 5'd7, 64'hAA);
    tick();
    in_write_back_flag = 1'b0;
    rd(3'd5, 5'd7, 5'd7);
    tick();
    check_eq("t5r7_before", rd_a_data, 64'hAA);
    reset = 1'b1;
    tick();
    check_eq("rst_run_ready", {63'd0, ready}, 64'd0);
    check_eq("rst_run_rd", rd_a_data, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check_eq("scrub2_ready_c100", {63'd0, ready}, 64'd0);
    reset = 1'b1;
    wr(3'd5, 5'd7, 64'hBB);
    tick();
    reset = 1'b0;
    in_write_back_flag = 1'b0;
    check_eq("rst_cycle_drop", {63'd0, dropped_write}, 64'd0);
    scrub_phase("scrub3", 1'b0);
    rd(3'd5, 5'd7, 5'd5);
    tick();
    check_eq("t5r7_after", rd_a_data, 64'd0);
    check_eq("t5r5_after", rd_b_data, 64'd0);
    rd(3'd2, 5'd5, 5'd9);
    tick();
    check_eq("t2r5_after", rd_a_data, 64'd0);
    check_eq("t2r9_after", rd_b_data, 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/wb_thread_regfile.md
Name: wb_thread_regfile

Overview:
- Multithreaded general-purpose register file: the consumer of the write-back stage.
- Accepts one write per cycle from the MEM2/WB pipeline register outputs and serves two synchronous read ports to decode.
- One register bank per hardware thread.
- After reset, a scrub FSM zeroes every entry one per cycle, so storage maps to block RAM without a parallel reset.

Parameters:
- DATA_WIDTH, 64, width of each register.
- REG_INDEX_BITS, 5, register index width; 32 registers per thread.
- THREAD_INDEX_BITS, 3, thread index width; 8 threads.
- Total entries ENTRIES = 2^(REG_INDEX_BITS+THREAD_INDEX_BITS) = 256 at defaults.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_write_back_flag  input  1  write enable from write-back.
- in_reg_index  input  REG_INDEX_BITS  destination register.
- in_thread_index  input  THREAD_INDEX_BITS  destination thread.
- in_data  input  DATA_WIDTH  write data.
- rd_thread_index  input  THREAD_INDEX_BITS  thread for both read ports.
- rd_a_index  input  REG_INDEX_BITS  read port A register.
- rd_b_index  input  REG_INDEX_BITS  read port B register.
- rd_a_data  output  DATA_WIDTH  registered read data A.
- rd_b_data  output  DATA_WIDTH  registered read data B.
- ready  output  1  high once scrub is complete; upstream stalls while low.
- dropped_write  output  1  one-cycle pulse when a write is discarded during scrub.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset; the polarity and synchronicity are fixed.
- Entry address = {thread_index, reg_index}.
- Reset values: ready=0, rd_a_data=0, rd_b_data=0, dropped_write=0, state=SCRUB, scrub_ctr=0. Storage contents are not reset directly.
- FSM has two states: SCRUB and RUN.
- SCRUB:
  - Each cycle, write 0 to entry scrub_ctr, then scrub_ctr++.
  - When scrub_ctr == ENTRIES-1 is written, go to RUN next cycle.
  - The scrub takes exactly ENTRIES cycles; ready rises on the cycle after the last scrub write.
- SCRUB port behaviour:
  - External writes are ignored.
  - If in_write_back_flag=1, dropped_write=1 in the following cycle.
  - rd_a_data and rd_b_data are held at 0.
- RUN:
  - ready=1.
  - If in_write_back_flag=1 and in_reg_index!=0, write in_data to entry {in_thread_index, in_reg_index} at posedge.
  - Writes to register 0 of any thread are discarded without a dropped_write pulse.
- Reads:
  - Latency 1: rd_x_data at cycle N+1 reflects the address presented at cycle N.
  - Register index 0 always reads 0, regardless of storage.
- Same-cycle write and read to the same entry: without the optional feature, read data is the old value (read-before-write).
- Banks are fully independent; a write to thread t never affects any other thread's entries.
- Reset asserted at any time, including mid-scrub or during RUN:
  - Immediately returns to SCRUB with scrub_ctr=0 and ready=0.
  - The full scrub repeats.
  - Writes presented in the reset cycle are discarded.
- No other state; there are no X-propagation paths from uninitialised storage after ready=1.

Optional Feature:
- WB_BYPASS_EN
- Defined:
  - In RUN, if in_write_back_flag=1, in_thread_index==rd_thread_index, in_reg_index==rd_x_index, and the index is nonzero, then rd_x_data next cycle = in_data (write-first).
  - Applies to each port independently.
- Undefined: read-before-write as stated in Behaviour; decode must stall one cycle on such a hazard.

Test Plan:
- Scrub timing: deassert reset at cycle 0 -> ready=0 through cycle 255, ready=1 at cycle 256; every register of threads 0 and 7 then reads 0.
- Write then read: in RUN, write thread 2 r5 = 0xDEADBEEF_00000001; next cycle read A t2 r5 -> 0xDEADBEEF_00000001 one cycle later; read B t3 r5 -> 0.
- Register 0: write thread 1 r0 = 0xFFFF...FF -> read t1 r0 returns 0; dropped_write stays 0.
- Collision: write t4 r9 = 0x1234 while reading t4 r9 in the same cycle -> rd_a_data = old value 0 without WB_BYPASS_EN, 0x1234 with it; the following read returns 0x1234 in both builds.
- Write during scrub: assert in_write_back_flag at scrub cycle 10 with t0 r3 = 0x55 -> dropped_write pulses one cycle; after ready, t0 r3 reads 0.
- Reset mid-operation: write t5 r7 = 0xAA in RUN, assert reset for 1 cycle at scrub cycle 100 of a second scrub -> ready stays low for a full 256 cycles after release; t5 r7 then reads 0.
